// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: PWM, soft-start ramp and enforced dead time on reversal.
// Define MOTOR_PWM_BRAKE_EN to drive 11 (active brake) in DEAD and in IDLE under stop code 11.
module motor_pwm_driver #(
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 50,
    parameter int DUTY_MAX     = 200,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] motor_in,
    input  logic [1:0] motor_en,
    output logic [3:0] hb_dir,
    output logic [1:0] hb_pwm,
    output logic [1:0] settled
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST  = '1;
    localparam logic [PWM_BITS:0]   DUTY_TOP  = (PWM_BITS + 1)'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] DUTY_FULL = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS:0]   STEP      = (PWM_BITS + 1)'(RAMP_STEP);
    localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

    typedef enum logic [1:0] {IDLE, RAMP, RUN, DEAD} state_e;

    logic [3:0]          motor_in_q;
    logic [1:0]          motor_en_q;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick;
    logic                period_start;

    // Shared timebase; period_start marks the wrap so duty changes land on a period boundary.
    always_comb begin
        tick         = (presc_q == PRE_LAST);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d    = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        period_start = tick && (pwm_cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motor_in_q <= '0;
            motor_en_q <= '0;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            motor_in_q <= motor_in;
            motor_en_q <= motor_en;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_e              state_q, state_d;
        logic [1:0]          dir_q, dir_d;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic [DEAD_W-1:0]   dead_q, dead_d;
        logic [1:0]          pin_q, pin_d;
        logic                pwm_q, pwm_d;
        logic                settled_q, settled_d;
        logic [1:0]          req;
        logic                en;
        logic                stop_req;
        logic [PWM_BITS:0]   duty_sum;

        assign req      = motor_in_q[2*c +: 2];
        assign en       = motor_en_q[c];
        assign stop_req = !en || (req == 2'b00) || (req == 2'b11);
        assign duty_sum = {1'b0, duty_q} + STEP;

        always_comb begin
            // NOTE: defaults first so no path through this block can infer a latch.
            state_d = state_q;
            dir_d   = dir_q;
            duty_d  = duty_q;
            dead_d  = dead_q;
            if (stop_req) begin
                // Stop/disable wins over everything, including a pending reversal.
                state_d = IDLE;
                duty_d  = '0;
                dead_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = RAMP;
                        dir_d   = req;
                        duty_d  = '0;
                    end
                    RAMP, RUN: begin
                        if (req != dir_q) begin
                            state_d = DEAD;
                            duty_d  = '0;
                            dead_d  = '0;
                        end else if (state_q == RAMP && period_start) begin
                            if (duty_sum >= DUTY_TOP) begin
                                duty_d  = DUTY_FULL;
                                state_d = RUN;
                            end else begin
                                duty_d = duty_sum[PWM_BITS-1:0];
                            end
                        end
                    end
                    DEAD: begin
                        // Dead time counts whole periods only; request changes do not restart it.
                        if (period_start) begin
                            if (dead_q == DEAD_LAST) begin
                                state_d = RAMP;
                                dir_d   = req;
                                duty_d  = '0;
                                dead_d  = '0;
                            end else begin
                                dead_d = dead_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Outputs are computed from next-state values so they register in step with the FSM.
        always_comb begin
            pin_d     = 2'b00;
            pwm_d     = 1'b0;
            settled_d = (state_d == RUN);
            case (state_d)
                RAMP, RUN: begin
                    pin_d = dir_d;
                    pwm_d = (pwm_cnt_d < duty_d);
                end
`ifdef MOTOR_PWM_BRAKE_EN
                DEAD: pin_d = 2'b11;
                IDLE: if (en && req == 2'b11) pin_d = 2'b11;
`endif
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                dir_q     <= '0;
                duty_q    <= '0;
                dead_q    <= '0;
                pin_q     <= '0;
                pwm_q     <= 1'b0;
                settled_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                dir_q     <= dir_d;
                duty_q    <= duty_d;
                dead_q    <= dead_d;
                pin_q     <= pin_d;
                pwm_q     <= pwm_d;
                settled_q <= settled_d;
            end
        end

        assign hb_dir[2*c +: 2] = pin_q;
        assign hb_pwm[c]        = pwm_q;
        assign settled[c]       = settled_q;
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: directed vector table, random phase against a
// period-arithmetic reference model, and hand-written reset / duty-cycle sequences.
module tb_motor_pwm_driver;

    localparam int P      = 1;
    localparam int PB     = 4;
    localparam int DMAX   = 12;
    localparam int STEP   = 4;
    localparam int DEADP  = 2;
    localparam int PERIOD = 1 << PB;
`ifdef MOTOR_PWM_BRAKE_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] motor_in;
    logic [1:0] motor_en;
    logic [3:0] hb_dir;
    logic [1:0] hb_pwm;
    logic [1:0] settled;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PWM_BITS    (PB),
        .PRESCALE    (P),
        .DUTY_MAX    (DMAX),
        .RAMP_STEP   (STEP),
        .DEAD_PERIODS(DEADP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .motor_in(motor_in),
        .motor_en(motor_en),
        .hb_dir  (hb_dir),
        .hb_pwm  (hb_pwm),
        .settled (settled)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each channel is off, accelerating, at full speed or pausing;
    // PWM position and period boundaries come straight from the edge count since reset.
    typedef enum int {M_OFF, M_ACCEL, M_FULL, M_PAUSE} mode_e;

    mode_e      m_mode   [2];
    int         m_level  [2];
    logic [1:0] m_dir    [2];
    int         m_pauses [2];
    logic [3:0] m_in_reg;
    logic [1:0] m_en_reg;
    int         edge_n;
    logic [3:0] exp_dir;
    logic [1:0] exp_pwm;
    logic [1:0] exp_set;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c]   = M_OFF;
            m_level[c]  = 0;
            m_dir[c]    = 2'b00;
            m_pauses[c] = 0;
        end
        m_in_reg = '0;
        m_en_reg = '0;
        edge_n   = 0;
    endtask

    task automatic model_edge();
        int         pos;
        bit         ps;
        logic [1:0] req;
        bit         en;
        bit         stopped;
        edge_n++;
        ps  = (edge_n % P == 0) && ((edge_n / P) % PERIOD == 0);
        pos = (edge_n / P) % PERIOD;
        for (int c = 0; c < 2; c++) begin
            req     = m_in_reg[2*c +: 2];
            en      = m_en_reg[c];
            stopped = !en || req == 2'b00 || req == 2'b11;
            if (stopped) begin
                m_mode[c]  = M_OFF;
                m_level[c] = 0;
            end else if (m_mode[c] == M_OFF) begin
                m_mode[c]  = M_ACCEL;
                m_dir[c]   = req;
                m_level[c] = 0;
            end else if (m_mode[c] == M_PAUSE) begin
                if (ps) begin
                    m_pauses[c]++;
                    if (m_pauses[c] == DEADP) begin
                        m_mode[c]  = M_ACCEL;
                        m_dir[c]   = req;
                        m_level[c] = 0;
                    end
                end
            end else if (req != m_dir[c]) begin
                m_mode[c]   = M_PAUSE;
                m_pauses[c] = 0;
                m_level[c]  = 0;
            end else if (m_mode[c] == M_ACCEL && ps) begin
                m_level[c] = (m_level[c] + STEP > DMAX) ? DMAX : m_level[c] + STEP;
                if (m_level[c] == DMAX) m_mode[c] = M_FULL;
            end

            exp_pwm[c] = 1'b0;
            exp_set[c] = (m_mode[c] == M_FULL);
            case (m_mode[c])
                M_ACCEL, M_FULL: begin
                    exp_dir[2*c +: 2] = m_dir[c];
                    exp_pwm[c]        = (pos < m_level[c]);
                end
                M_PAUSE: exp_dir[2*c +: 2] = BRK ? 2'b11 : 2'b00;
                default: exp_dir[2*c +: 2] = (BRK && en && req == 2'b11) ? 2'b11 : 2'b00;
            endcase
        end
        m_in_reg = motor_in;
        m_en_reg = motor_en;
    endtask

    // One clock: advance the model on the edge, compare at the following falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("model hb_dir @%0d", edge_n), hb_dir, exp_dir);
            check($sformatf("model hb_pwm @%0d", edge_n), hb_pwm, exp_pwm);
            check($sformatf("model settled @%0d", edge_n), settled, exp_set);
        end
    endtask

    typedef struct {
        logic [3:0] in;
        logic [1:0] en;
        int         hold;
        logic [3:0] dir;
        logic [3:0] dir_brk;
        logic [1:0] set;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int cnt1;
        int pick;
        logic [1:0] pair;

        //          in       en     hold  dir      dir_brk  settled
        vec[0]  = '{4'b0101, 2'b11,  2, 4'b0101, 4'b0101, 2'b00};
        vec[1]  = '{4'b0101, 2'b11, 46, 4'b0101, 4'b0101, 2'b11};
        vec[2]  = '{4'b1010, 2'b11,  2, 4'b0000, 4'b1111, 2'b00};
        vec[3]  = '{4'b1010, 2'b11, 29, 4'b0000, 4'b1111, 2'b00};
        vec[4]  = '{4'b1010, 2'b11,  1, 4'b1010, 4'b1010, 2'b00};
        vec[5]  = '{4'b1010, 2'b11, 48, 4'b1010, 4'b1010, 2'b11};
        vec[6]  = '{4'b0101, 2'b11,  5, 4'b0000, 4'b1111, 2'b00};
        vec[7]  = '{4'b1010, 2'b11, 26, 4'b0000, 4'b1111, 2'b00};
        vec[8]  = '{4'b1010, 2'b11,  1, 4'b1010, 4'b1010, 2'b00};
        vec[9]  = '{4'b1010, 2'b11, 48, 4'b1010, 4'b1010, 2'b11};
        vec[10] = '{4'b1010, 2'b01,  2, 4'b0010, 4'b0010, 2'b01};
        vec[11] = '{4'b1111, 2'b11,  2, 4'b0000, 4'b1111, 2'b00};

        rst_n    = 1'b0;
        motor_en = 2'b11;
        motor_in = 4'b0101;
        repeat (3) @(negedge clk);
        check("reset hb_dir", hb_dir, 4'b0000);
        check("reset hb_pwm", hb_pwm, 2'b00);
        check("reset settled", settled, 2'b00);

        rst_n = 1'b1;
        model_reset();

        for (int v = 0; v < NV; v++) begin
            motor_in = vec[v].in;
            motor_en = vec[v].en;
            step(vec[v].hold);
            check($sformatf("vec%0d hb_dir", v), hb_dir, BRK ? vec[v].dir_brk : vec[v].dir);
            check($sformatf("vec%0d settled", v), settled, vec[v].set);
        end

        for (int r = 0; r < 150; r++) begin
            for (int c = 0; c < 2; c++) begin
                pick = int'($urandom_range(0, 9));
                pair = (pick < 4) ? 2'b01 : (pick < 8) ? 2'b10 : 2'($urandom);
                motor_in[2*c +: 2] = pair;
            end
            motor_en = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom);
            step(int'($urandom_range(1, 40)));
        end

        motor_en = 2'b00;
        step(3);
        motor_in = 4'b0101;
        motor_en = 2'b11;
        step(70);
        check("final settled", settled, 2'b11);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1);
            if (hb_pwm[0]) cnt0++;
            if (hb_pwm[1]) cnt1++;
        end
        check("duty ch0 high clks", cnt0, DMAX);
        check("duty ch1 high clks", cnt1, DMAX);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset hb_dir", hb_dir, 4'b0000);
        check("async reset hb_pwm", hb_pwm, 2'b00);
        check("async reset settled", settled, 2'b00);
        @(negedge clk);
        check("held reset hb_dir", hb_dir, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
